mem_stage: RTL and testbench

Memory-access stage of the 5-stage in-order CPU pipeline, sitting between EXE and WB.
- Receives EXE results over a valid/allow handshake.
- Waits for the data-SRAM response of loads and stores that EXE issued.
- Aligns and sign/zero-extends load data.
- Transmits the 70-bit MEM-to-WB bus to WB, honouring WB_allow.
- Publishes a forwarding/blocking bus to ID.

---
 rtl/cpu_pipe_pkg.sv | 48 ++++
 rtl/load_align.sv | 40 ++++
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pipe_pkg
// Purpose  : Shared definitions for the in-order pipeline stages.
//            - Inter-stage bus widths.
//            - EXE-to-MEM and MEM-to-WB field offsets.
//            - Load-operation encodings.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package cpu_pipe_pkg;

  localparam int EXE_BUS_W = 75;
  localparam int WB_BUS_W  = 70;
  localparam int FWD_W     = 39;

  // EXE_to_MEM_bus field positions
  localparam int E_MEM_REQ  = 74;
  localparam int E_IS_LOAD  = 73;
  localparam int E_LD_OP_HI = 72;
  localparam int E_LD_OP_LO = 70;
  localparam int E_GR_WE    = 69;
  localparam int E_DEST_HI  = 68;
  localparam int E_DEST_LO  = 64;
  localparam int E_ALU_HI   = 63;
  localparam int E_ALU_LO   = 32;
  localparam int E_PC_HI    = 31;
  localparam int E_PC_LO    = 0;

  // MEM_to_WB_bus field positions
  localparam int W_GR_WE  = 69;
  localparam int W_DEST_HI = 68;
  localparam int W_DEST_LO = 64;
  localparam int W_RES_HI  = 63;
  localparam int W_RES_LO  = 32;
  localparam int W_PC_HI   = 31;
  localparam int W_PC_LO   = 0;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_H  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4
  } ld_op_e;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Selects the addressed byte/halfword of a load response word and
//            sign- or zero-extends it to 32 bits.
// Ports    : rdata_i  [31:0] raw word returned by the data SRAM
//            off_i    [1:0]  byte offset within the word
//            ld_op_i  [2:0]  load operation (LW/LB/LH/LBU/LHU)
//            data_o   [31:0] aligned, extended load value
// Revision : 1.0  initial release
// ============================================================================
module load_align
  import cpu_pipe_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  ld_op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    // Halfword accesses use only the upper offset bit; off_i[0] is ignored.
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = rdata_i;
    case (ld_op_i)
      LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
      LD_BU:   data_o = {24'd0, byte_sel};
      LD_HU:   data_o = {16'd0, half_sel};
      // LD_W and the unused encodings return the whole word
      default: data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage between EXE and WB. Holds one instruction,
//            waits for its data-SRAM response, aligns load data, and drives
//            the WB bus and the ID forwarding/blocking bus.
// Ports    : clk, reset                   clock, synchronous active-high reset
//            EXE_to_MEM_valid/_bus        incoming instruction from EXE
//            MEM_allow                    MEM can accept this cycle
//            WB_allow                     WB can accept this cycle
//            MEM_to_WB_valid/_bus         outgoing instruction to WB
//            data_sram_data_ok/_rdata     data-SRAM response
//            MEM_to_ID_forward            {we, dest, result, load_block}
//            mem_stall_cycles             stall counter (MEM_STALL_CNT_EN only)
// Options  : MEM_STALL_CNT_EN  adds the mem_stall_cycles counter/port
// Revision : 1.0  initial release
// ============================================================================
module mem_stage
  import cpu_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 EXE_to_MEM_valid,
  input  logic [EXE_BUS_W-1:0] EXE_to_MEM_bus,
  output logic                 MEM_allow,
  input  logic                 WB_allow,
  output logic                 MEM_to_WB_valid,
  output logic [WB_BUS_W-1:0]  MEM_to_WB_bus,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  output logic [FWD_W-1:0]     MEM_to_ID_forward
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [31:0]          mem_stall_cycles
`endif
);

  logic                 mem_valid_q, mem_valid_d;
  logic [EXE_BUS_W-1:0] bus_q, bus_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [31:0]          buf_data_q, buf_data_d;

  logic        mem_req, is_load, gr_we;
  logic [2:0]  ld_op;
  logic [4:0]  dest;
  logic [31:0] alu_result, pc;

  assign mem_req    = bus_q[E_MEM_REQ];
  assign is_load    = bus_q[E_IS_LOAD];
  assign ld_op      = bus_q[E_LD_OP_HI:E_LD_OP_LO];
  assign gr_we      = bus_q[E_GR_WE];
  assign dest       = bus_q[E_DEST_HI:E_DEST_LO];
  assign alu_result = bus_q[E_ALU_HI:E_ALU_LO];
  assign pc         = bus_q[E_PC_HI:E_PC_LO];

  logic        ready_go, leave, resp_take;
  logic [31:0] load_raw, load_ext, final_result;

  assign ready_go        = !mem_req || data_sram_data_ok || buf_valid_q;
  assign MEM_allow       = !mem_valid_q || (ready_go && WB_allow);
  assign MEM_to_WB_valid = mem_valid_q && ready_go;
  assign leave           = MEM_to_WB_valid && WB_allow;

  // Only a response belonging to the resident memory instruction is kept;
  // responses with no valid requester (e.g. left over from before a reset)
  // are dropped here.
  assign resp_take = data_sram_data_ok && mem_valid_q && mem_req && !buf_valid_q;

  // A live response takes precedence; otherwise replay the buffered one so
  // the data survives a WB back-pressure stall.
  assign load_raw = data_sram_data_ok ? data_sram_rdata : buf_data_q;

  load_align u_load_align (
    .rdata_i (load_raw),
    .off_i   (alu_result[1:0]),
    .ld_op_i (ld_op),
    .data_o  (load_ext)
  );

  assign final_result = (mem_req && is_load) ? load_ext : alu_result;

  assign MEM_to_WB_bus = {gr_we, dest, final_result, pc};

  assign MEM_to_ID_forward = {gr_we && mem_valid_q,
                              mem_valid_q ? dest : 5'd0,
                              final_result,
                              mem_valid_q && mem_req && is_load && !ready_go};

  always_comb begin
    mem_valid_d = mem_valid_q;
    bus_d       = bus_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (MEM_allow) begin
      mem_valid_d = EXE_to_MEM_valid;
      if (EXE_to_MEM_valid) begin
        bus_d = EXE_to_MEM_bus;
      end
    end
    // Leaving wins over capture: a response consumed in the same cycle it
    // arrives never needs buffering.
    if (leave) begin
      buf_valid_d = 1'b0;
    end else if (resp_take) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      bus_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      bus_q       <= bus_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles an instruction is resident but still waiting on memory;
  // wraps naturally at 2^32.
  assign stall_cnt_d      = (mem_valid_q && !ready_go) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  assign mem_stall_cycles = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  // No stall counter in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage: directed scenarios followed by
//            randomized traffic checked against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_v;
  logic [74:0] exe_bus;
  logic        mem_allow;
  logic        wb_allow;
  logic        to_wb_v;
  logic [69:0] to_wb_bus;
  logic        dok;
  logic [31:0] rdata;
  logic [38:0] fwd;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .EXE_to_MEM_valid  (exe_v),
    .EXE_to_MEM_bus    (exe_bus),
    .MEM_allow         (mem_allow),
    .WB_allow          (wb_allow),
    .MEM_to_WB_valid   (to_wb_v),
    .MEM_to_WB_bus     (to_wb_bus),
    .data_sram_data_ok (dok),
    .data_sram_rdata   (rdata),
    .MEM_to_ID_forward (fwd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [74:0] b, input bit wb, input bit d,
                       input logic [31:0] rd);
    exe_v    = v;
    exe_bus  = b;
    wb_allow = wb;
    dok      = d;
    rdata    = rd;
    #1;
  endtask

  function automatic logic [74:0] mk(input bit mreq, input bit isl, input logic [2:0] op,
                                     input bit we, input logic [4:0] dst,
                                     input logic [31:0] alu, input logic [31:0] pcv);
    return {mreq, isl, op, we, dst, alu, pcv};
  endfunction

  // Reference load semantics written with shifts, masks and arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd2:    return (h >= 32'h8000)  ? h - 32'h10000 : h;
      3'd3:    return b;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  task automatic run_load(input string tag, input logic [74:0] b, input logic [31:0] rd,
                          input logic [31:0] exp);
    drive(1'b1, b, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 75'd0, 1'b1, 1'b1, rd);
    chk({tag, "_v"}, 128'(to_wb_v), 128'(1'b1));
    chk({tag, "_res"}, 128'(to_wb_bus[63:32]), 128'(exp));
    tick();
    chk({tag, "_gone"}, 128'(to_wb_v), 128'(1'b0));
  endtask

  // random-phase model state
  bit          have, got, ev, wb, d, ready, e_v, e_allow;
  logic [74:0] cur, eb;
  logic [31:0] gdata, rd, fin;
  int          wait_c, kind;

  initial begin
    reset = 1'b1;
    drive(1'b0, 75'd0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("rst_allow", 128'(mem_allow), 128'(1'b1));
    chk("rst_wbv", 128'(to_wb_v), 128'(1'b0));
    chk("rst_fwd", 128'(fwd), 128'(39'd0));
    chk("rst_bus", 128'(to_wb_bus), 128'(70'd0));
    reset = 1'b0;

    // ALU instruction: one-cycle pass through
    drive(1'b1, mk(1'b0, 1'b0, 3'd0, 1'b1, 5'd5, 32'h12345678, 32'h1C000000), 1'b1, 1'b0, 32'h0);
    chk("alu_allow", 128'(mem_allow), 128'(1'b1));
    tick();
    drive(1'b0, 75'd0, 1'b1, 1'b0, 32'h0);
    chk("alu_wbv", 128'(to_wb_v), 128'(1'b1));
    chk("alu_bus", 128'(to_wb_bus), 128'({1'b1, 5'd5, 32'h12345678, 32'h1C000000}));
    chk("alu_fwd", 128'(fwd), 128'({1'b1, 5'd5, 32'h12345678, 1'b0}));
    tick();
    chk("alu_gone", 128'(to_wb_v), 128'(1'b0));

    // LB waiting two cycles for its response
    drive(1'b1, mk(1'b1, 1'b1, 3'd1, 1'b1, 5'd3, 32'h1003, 32'h1C000004), 1'b1, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 75'd0, 1'b1, 1'b0, 32'hFFFFFFFF);
      chk("lb_wait_allow", 128'(mem_allow), 128'(1'b0));
      chk("lb_wait_block", 128'(fwd[0]), 128'(1'b1));
      chk("lb_wait_v", 128'(to_wb_v), 128'(1'b0));
      tick();
    end
    drive(1'b0, 75'd0, 1'b1, 1'b1, 32'h80FF0000);
    chk("lb_v", 128'(to_wb_v), 128'(1'b1));
    chk("lb_res", 128'(to_wb_bus[63:32]), 128'(32'hFFFFFF80));
    chk("lb_block", 128'(fwd[0]), 128'(1'b0));
    tick();

    run_load("lhu", mk(1'b1, 1'b1, 3'd4, 1'b1, 5'd7, 32'h2002, 32'h1C000008),
             32'hBEEF1234, 32'h0000BEEF);
    run_load("lh", mk(1'b1, 1'b1, 3'd2, 1'b1, 5'd7, 32'h2002, 32'h1C00000C),
             32'hBEEF1234, 32'hFFFFBEEF);

    // LW response arrives while WB is stalled for 3 cycles
    drive(1'b1, mk(1'b1, 1'b1, 3'd0, 1'b1, 5'd9, 32'h3000, 32'h1C000010), 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 75'd0, 1'b0, 1'b1, 32'hA5A5A5A5);
    chk("lw_v", 128'(to_wb_v), 128'(1'b1));
    chk("lw_allow", 128'(mem_allow), 128'(1'b0));
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 75'd0, 1'b0, 1'b0, 32'h0);
      chk("lw_hold_v", 128'(to_wb_v), 128'(1'b1));
      chk("lw_hold_res", 128'(to_wb_bus[63:32]), 128'(32'hA5A5A5A5));
      tick();
    end
    drive(1'b0, 75'd0, 1'b1, 1'b0, 32'h0);
    chk("lw_res", 128'(to_wb_bus[63:32]), 128'(32'hA5A5A5A5));
    chk("lw_allow_go", 128'(mem_allow), 128'(1'b1));
    tick();

    // Store: held until its response; the buffer from the LW must be gone
    drive(1'b1, mk(1'b1, 1'b0, 3'd0, 1'b0, 5'd4, 32'h4000, 32'h1C000014), 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 75'd0, 1'b1, 1'b0, 32'h0);
    chk("st_wait_v", 128'(to_wb_v), 128'(1'b0));
    chk("st_fwd_we", 128'(fwd[38]), 128'(1'b0));
    chk("st_wait_block", 128'(fwd[0]), 128'(1'b0));
    tick();
    drive(1'b0, 75'd0, 1'b1, 1'b1, 32'h55);
    chk("st_v", 128'(to_wb_v), 128'(1'b1));
    chk("st_we", 128'(to_wb_bus[69]), 128'(1'b0));
    chk("st_block", 128'(fwd[0]), 128'(1'b0));
    tick();

    // Reset during a waiting load, with data_ok on the reset cycle and after
    drive(1'b1, mk(1'b1, 1'b1, 3'd0, 1'b1, 5'd10, 32'h5000, 32'h1C000018), 1'b1, 1'b0, 32'h0);
    tick();
    reset = 1'b1;
    drive(1'b0, 75'd0, 1'b0, 1'b1, 32'hDEADBEEF);
    tick();
    reset = 1'b0;
    drive(1'b0, 75'd0, 1'b1, 1'b1, 32'hCAFEF00D);
    chk("rs_v", 128'(to_wb_v), 128'(1'b0));
    chk("rs_allow", 128'(mem_allow), 128'(1'b1));
    chk("rs_fwd", 128'(fwd), 128'(39'd0));
    tick();
    drive(1'b1, mk(1'b1, 1'b1, 3'd0, 1'b1, 5'd11, 32'h6000, 32'h1C00001C), 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 75'd0, 1'b1, 1'b0, 32'h0);
    chk("rs_next_wait_v", 128'(to_wb_v), 128'(1'b0));
    tick();
    drive(1'b0, 75'd0, 1'b1, 1'b1, 32'h13579BDF);
    chk("rs_next_v", 128'(to_wb_v), 128'(1'b1));
    chk("rs_next_res", 128'(to_wb_bus[63:32]), 128'(32'h13579BDF));
    tick();

    // Randomized traffic against a transaction model
    have   = 1'b0;
    got    = 1'b0;
    ev     = 1'b0;
    cur    = '0;
    eb     = '0;
    gdata  = '0;
    wait_c = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!ev && ($urandom_range(0, 2) != 0)) begin
        ev   = 1'b1;
        kind = int'($urandom_range(0, 2));
        case (kind)
          0:       eb = mk(1'b0, 1'($urandom), 3'($urandom), 1'($urandom), 5'($urandom),
                           $urandom, $urandom);
          1:       eb = mk(1'b1, 1'b1, 3'($urandom), 1'b1, 5'($urandom), $urandom, $urandom);
          default: eb = mk(1'b1, 1'b0, 3'($urandom), 1'b0, 5'($urandom), $urandom, $urandom);
        endcase
      end
      wb = ($urandom_range(0, 3) != 0);
      d  = have && cur[74] && !got && (wait_c == 0);
      rd = $urandom;
      drive(ev, eb, wb, d, rd);

      ready   = !cur[74] || d || got;
      e_v     = have && ready;
      e_allow = !have || (ready && wb);
      fin     = (cur[74] && cur[73]) ? ref_load(cur[72:70], cur[33:32], d ? rd : gdata)
                                     : cur[63:32];
      chk("rnd_allow", 128'(mem_allow), 128'(e_allow));
      chk("rnd_wbv", 128'(to_wb_v), 128'(e_v));
      if (have) begin
        chk("rnd_bus", 128'(to_wb_bus), 128'({cur[69], cur[68:64], fin, cur[31:0]}));
        chk("rnd_fwd", 128'(fwd),
            128'({cur[69], cur[68:64], fin, cur[74] && cur[73] && !ready}));
      end else begin
        chk("rnd_fwd_idle", 128'({fwd[38:33], fwd[0]}), 128'(7'd0));
      end

      if (have && e_v && wb) begin
        have = 1'b0;
      end else if (have && d) begin
        got   = 1'b1;
        gdata = rd;
      end else if (have && cur[74] && !got && wait_c > 0) begin
        wait_c--;
      end
      if (e_allow && ev) begin
        have   = 1'b1;
        cur    = eb;
        got    = 1'b0;
        wait_c = int'($urandom_range(0, 3));
        ev     = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
